// File: rtl/ccip_txn_monitor_if.sv
// CCI-P read/write event bundle seen by the transaction monitor.
// The AFU-side driver uses master; the monitor uses slave.
interface ccip_txn_monitor_if #(
    parameter int TAG_WIDTH = 8
);
    logic                 c0_req_valid;
    logic [TAG_WIDTH-1:0] c0_req_tag;
    logic [1:0]           c0_req_len;
    logic                 c0_rsp_valid;
    logic [TAG_WIDTH-1:0] c0_rsp_tag;
    logic                 c1_req_valid;
    logic                 c1_rsp_valid;

    modport master (
        output c0_req_valid, c0_req_tag, c0_req_len,
        output c0_rsp_valid, c0_rsp_tag,
        output c1_req_valid, c1_rsp_valid
    );

    modport slave (
        input c0_req_valid, c0_req_tag, c0_req_len,
        input c0_rsp_valid, c0_rsp_tag,
        input c1_req_valid, c1_rsp_valid
    );
endinterface

// File: rtl/ccip_txn_monitor.sv
// CCI-P transaction monitor: per-tag read tracking, latency,
// timeout scan, protocol error capture and channel counters.
module ccip_txn_monitor #(
    parameter int TAG_WIDTH      = 8,
    parameter int LAT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 SoftReset,
    ccip_txn_monitor_if.slave    bus,
    input  logic                 stats_clear,
    output logic [CNT_WIDTH-1:0] rd_req_cnt,
    output logic [CNT_WIDTH-1:0] rd_rsp_cnt,
    output logic [CNT_WIDTH-1:0] wr_req_cnt,
    output logic [CNT_WIDTH-1:0] wr_rsp_cnt,
    output logic [TAG_WIDTH:0]   rd_outstanding,
    output logic [CNT_WIDTH-1:0] wr_outstanding,
    output logic [LAT_WIDTH-1:0] max_rd_latency,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic                 err_sticky,
    output logic [2:0]           err_first_code,
    output logic [TAG_WIDTH-1:0] err_first_tag
);
    localparam int DEPTH = 1 << TAG_WIDTH;

    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [LAT_WIDTH-1:0] lat_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef logic [TAG_WIDTH:0]   occ_t;

    logic       valid_q [DEPTH];
    logic [2:0] rem_q   [DEPTH];
    lat_t       ts_q    [DEPTH];

    lat_t now_q;
    tag_t scan_q;
    cnt_t rd_req_q, rd_rsp_q, wr_req_q, wr_rsp_q;
    cnt_t wr_out_q, wr_out_d;
    occ_t rd_out_q, rd_out_d;
    lat_t max_lat_q, max_lat_d;
    logic err_valid_q, err_sticky_q;
    logic [2:0] err_code_q, err_first_code_q;
    tag_t err_first_tag_q;

    tag_t       rq_tag, rs_tag;
    logic       rs_hit, rs_orph, rs_free;
    lat_t       rs_lat, sc_age;
    logic       to_hit;
    logic       rq_bad, rq_busy, rq_dup, rq_alloc;
    logic [2:0] rq_rem;
    logic       wr_err;
    logic       err_any;
    logic [2:0] err_code_d;
    tag_t       err_tag_d;

    assign rq_tag = bus.c0_req_tag;
    assign rs_tag = bus.c0_rsp_tag;

    always_comb begin
        rs_hit  = bus.c0_rsp_valid && valid_q[rs_tag];
        rs_orph = bus.c0_rsp_valid && !valid_q[rs_tag];
        rs_free = rs_hit && (rem_q[rs_tag] == 3'd1);
        rs_lat  = now_q - ts_q[rs_tag];
        sc_age  = now_q - ts_q[scan_q];
        // A live response on the scanned entry wins over its timeout
        to_hit  = valid_q[scan_q]
               && (sc_age >= lat_t'(TIMEOUT_CYCLES))
               && !(rs_hit && (rs_tag == scan_q));
        rq_bad  = bus.c0_req_valid && (bus.c0_req_len == 2'b10);
        rq_busy = valid_q[rq_tag]
               && !(rs_free && (rs_tag == rq_tag))
               && !(to_hit && (scan_q == rq_tag));
        rq_dup   = bus.c0_req_valid && !rq_bad && rq_busy;
        rq_alloc = bus.c0_req_valid && !rq_bad && !rq_busy;
        case (bus.c0_req_len)
            2'b00:   rq_rem = 3'd1;
            2'b01:   rq_rem = 3'd2;
            2'b11:   rq_rem = 3'd4;
            default: rq_rem = 3'd0;
        endcase
        wr_err = bus.c1_rsp_valid && !bus.c1_req_valid
              && (wr_out_q == '0);
    end

    always_comb begin
        err_any    = 1'b1;
        err_code_d = 3'd0;
        err_tag_d  = '0;
        if (rq_dup) begin
            err_code_d = 3'd1;
            err_tag_d  = rq_tag;
        end else if (rs_orph) begin
            err_code_d = 3'd2;
            err_tag_d  = rs_tag;
        end else if (to_hit) begin
            err_code_d = 3'd3;
            err_tag_d  = scan_q;
        end else if (rq_bad) begin
            err_code_d = 3'd4;
            err_tag_d  = rq_tag;
        end else if (wr_err) begin
            err_code_d = 3'd5;
        end else begin
            err_any = 1'b0;
        end
    end

    always_comb begin
        rd_out_d = rd_out_q + occ_t'(rq_alloc)
                 - occ_t'(rs_free) - occ_t'(to_hit);
        wr_out_d = wr_out_q;
        if (bus.c1_req_valid && !bus.c1_rsp_valid) begin
            wr_out_d = wr_out_q + 1'b1;
        end else if (!bus.c1_req_valid && bus.c1_rsp_valid
                     && (wr_out_q != '0)) begin
            wr_out_d = wr_out_q - 1'b1;
        end
        max_lat_d = max_lat_q;
        if (rs_free && (rs_lat > max_lat_q)) begin
            max_lat_d = rs_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
            now_q            <= '0;
            scan_q           <= '0;
            rd_req_q         <= '0;
            rd_rsp_q         <= '0;
            wr_req_q         <= '0;
            wr_rsp_q         <= '0;
            wr_out_q         <= '0;
            rd_out_q         <= '0;
            max_lat_q        <= '0;
            err_valid_q      <= 1'b0;
            err_code_q       <= 3'd0;
            err_sticky_q     <= 1'b0;
            err_first_code_q <= 3'd0;
            err_first_tag_q  <= '0;
        end else begin
            now_q  <= now_q + 1'b1;
            scan_q <= scan_q + 1'b1;
            // Response, then timeout, then allocation: later writes win
            if (rs_hit) begin
                rem_q[rs_tag] <= rem_q[rs_tag] - 3'd1;
                if (rs_free) begin
                    valid_q[rs_tag] <= 1'b0;
                end
            end
            if (to_hit) begin
                valid_q[scan_q] <= 1'b0;
            end
            if (rq_alloc) begin
                valid_q[rq_tag] <= 1'b1;
                rem_q[rq_tag]   <= rq_rem;
                ts_q[rq_tag]    <= now_q;
            end
            rd_out_q <= rd_out_d;
            wr_out_q <= wr_out_d;
            if (stats_clear) begin
                rd_req_q         <= '0;
                rd_rsp_q         <= '0;
                wr_req_q         <= '0;
                wr_rsp_q         <= '0;
                max_lat_q        <= '0;
                err_valid_q      <= 1'b0;
                err_code_q       <= 3'd0;
                err_sticky_q     <= 1'b0;
                err_first_code_q <= 3'd0;
                err_first_tag_q  <= '0;
            end else begin
                rd_req_q    <= rd_req_q + cnt_t'(bus.c0_req_valid);
                rd_rsp_q    <= rd_rsp_q + cnt_t'(bus.c0_rsp_valid);
                wr_req_q    <= wr_req_q + cnt_t'(bus.c1_req_valid);
                wr_rsp_q    <= wr_rsp_q + cnt_t'(bus.c1_rsp_valid);
                max_lat_q   <= max_lat_d;
                err_valid_q <= err_any;
                err_code_q  <= err_code_d;
                if (err_any && !err_sticky_q) begin
                    err_sticky_q     <= 1'b1;
                    err_first_code_q <= err_code_d;
                    err_first_tag_q  <= err_tag_d;
                end
            end
        end
    end

    assign rd_req_cnt     = rd_req_q;
    assign rd_rsp_cnt     = rd_rsp_q;
    assign wr_req_cnt     = wr_req_q;
    assign wr_rsp_cnt     = wr_rsp_q;
    assign rd_outstanding = rd_out_q;
    assign wr_outstanding = wr_out_q;
    assign max_rd_latency = max_lat_q;
    assign err_valid      = err_valid_q;
    assign err_code       = err_code_q;
    assign err_sticky     = err_sticky_q;
    assign err_first_code = err_first_code_q;
    assign err_first_tag  = err_first_tag_q;
endmodule

// File: tb/tb_ccip_txn_monitor.sv
// Directed bench for ccip_txn_monitor: per-cycle vector table
// followed by multi-cycle latency, timeout and reset sequences.
module tb_ccip_txn_monitor;
    localparam int TW  = 8;
    localparam int LW  = 16;
    localparam int TMO = 4096;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          SoftReset;
    logic          stats_clear;
    logic [CW-1:0] rd_req_cnt, rd_rsp_cnt, wr_req_cnt, wr_rsp_cnt;
    logic [TW:0]   rd_outstanding;
    logic [CW-1:0] wr_outstanding;
    logic [LW-1:0] max_rd_latency;
    logic          err_valid, err_sticky;
    logic [2:0]    err_code, err_first_code;
    logic [TW-1:0] err_first_tag;

    int checks = 0;
    int errors = 0;

    ccip_txn_monitor_if #(.TAG_WIDTH(TW)) bus ();

    ccip_txn_monitor #(
        .TAG_WIDTH(TW), .LAT_WIDTH(LW),
        .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .SoftReset(SoftReset), .bus(bus),
        .stats_clear(stats_clear),
        .rd_req_cnt(rd_req_cnt), .rd_rsp_cnt(rd_rsp_cnt),
        .wr_req_cnt(wr_req_cnt), .wr_rsp_cnt(wr_rsp_cnt),
        .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding),
        .max_rd_latency(max_rd_latency),
        .err_valid(err_valid), .err_code(err_code),
        .err_sticky(err_sticky), .err_first_code(err_first_code),
        .err_first_tag(err_first_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rqv;
        logic [TW-1:0] rqt;
        logic [1:0]    rql;
        logic          rsv;
        logic [TW-1:0] rst;
        logic          wq;
        logic          wr;
        logic          ev;
        logic [2:0]    ec;
        logic [TW:0]   rdo;
        logic [CW-1:0] wro;
    } vec_t;

    vec_t tv [16];

    task automatic vset(input int i, input logic rqv,
                        input logic [TW-1:0] rqt, input logic [1:0] rql,
                        input logic rsv, input logic [TW-1:0] rst,
                        input logic wq, input logic wr,
                        input logic ev, input logic [2:0] ec,
                        input logic [TW:0] rdo, input logic [CW-1:0] wro);
        tv[i].rqv = rqv; tv[i].rqt = rqt; tv[i].rql = rql;
        tv[i].rsv = rsv; tv[i].rst = rst;
        tv[i].wq  = wq;  tv[i].wr  = wr;
        tv[i].ev  = ev;  tv[i].ec  = ec;
        tv[i].rdo = rdo; tv[i].wro = wro;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.c0_req_valid = 1'b0;
        bus.c0_req_tag   = '0;
        bus.c0_req_len   = 2'b00;
        bus.c0_rsp_valid = 1'b0;
        bus.c0_rsp_tag   = '0;
        bus.c1_req_valid = 1'b0;
        bus.c1_rsp_valid = 1'b0;
        stats_clear      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_req(input logic [TW-1:0] t, input logic [1:0] l);
        bus.c0_req_valid = 1'b1;
        bus.c0_req_tag   = t;
        bus.c0_req_len   = l;
    endtask

    task automatic rd_rsp(input logic [TW-1:0] t);
        bus.c0_rsp_valid = 1'b1;
        bus.c0_rsp_tag   = t;
    endtask

    task automatic chk_zero(input string p);
        chk({p, " rd_req_cnt"}, rd_req_cnt, 0);
        chk({p, " rd_rsp_cnt"}, rd_rsp_cnt, 0);
        chk({p, " wr_req_cnt"}, wr_req_cnt, 0);
        chk({p, " wr_rsp_cnt"}, wr_rsp_cnt, 0);
        chk({p, " rd_out"}, 32'(rd_outstanding), 0);
        chk({p, " wr_out"}, wr_outstanding, 0);
        chk({p, " max_lat"}, 32'(max_rd_latency), 0);
        chk({p, " err_valid"}, 32'(err_valid), 0);
        chk({p, " err_code"}, 32'(err_code), 0);
        chk({p, " err_sticky"}, 32'(err_sticky), 0);
        chk({p, " first_code"}, 32'(err_first_code), 0);
        chk({p, " first_tag"}, 32'(err_first_tag), 0);
    endtask

    initial begin
        int n;
        int errs_seen;
        idle();
        SoftReset = 1'b1;
        // {rqv,rqt,rql, rsv,rst, wq,wr, ev,ec, rdo,wro}
        vset(0,  0, 8'h00, 2'b00, 0, 8'h00, 0, 1, 1, 3'd5, 9'd0, 0);
        vset(1,  0, 8'h00, 2'b00, 0, 8'h00, 1, 0, 0, 3'd0, 9'd0, 1);
        vset(2,  0, 8'h00, 2'b00, 0, 8'h00, 1, 0, 0, 3'd0, 9'd0, 2);
        vset(3,  0, 8'h00, 2'b00, 0, 8'h00, 1, 1, 0, 3'd0, 9'd0, 2);
        vset(4,  0, 8'h00, 2'b00, 0, 8'h00, 0, 1, 0, 3'd0, 9'd0, 1);
        vset(5,  0, 8'h00, 2'b00, 0, 8'h00, 0, 1, 0, 3'd0, 9'd0, 0);
        vset(6,  0, 8'h00, 2'b00, 0, 8'h00, 1, 1, 0, 3'd0, 9'd0, 0);
        vset(7,  1, 8'h30, 2'b10, 0, 8'h00, 0, 0, 1, 3'd4, 9'd0, 0);
        vset(8,  1, 8'h31, 2'b00, 0, 8'h00, 0, 0, 0, 3'd0, 9'd1, 0);
        vset(9,  0, 8'h00, 2'b00, 1, 8'h32, 0, 0, 1, 3'd2, 9'd1, 0);
        vset(10, 0, 8'h00, 2'b00, 1, 8'h31, 0, 0, 0, 3'd0, 9'd0, 0);
        vset(11, 1, 8'h40, 2'b01, 0, 8'h00, 0, 0, 0, 3'd0, 9'd1, 0);
        vset(12, 1, 8'h40, 2'b00, 1, 8'h40, 0, 0, 1, 3'd1, 9'd1, 0);
        vset(13, 0, 8'h00, 2'b00, 1, 8'h40, 0, 0, 0, 3'd0, 9'd0, 0);
        vset(14, 1, 8'h41, 2'b00, 1, 8'h42, 0, 1, 1, 3'd2, 9'd1, 0);
        vset(15, 0, 8'h00, 2'b00, 1, 8'h41, 0, 0, 0, 3'd0, 9'd0, 0);

        // Reset with traffic present: inputs must be ignored
        step();
        bus.c1_req_valid = 1'b1;
        rd_req(8'h01, 2'b00);
        step();
        chk_zero("reset");
        idle();
        SoftReset = 1'b0;

        foreach (tv[i]) begin
            bus.c0_req_valid = tv[i].rqv;
            bus.c0_req_tag   = tv[i].rqt;
            bus.c0_req_len   = tv[i].rql;
            bus.c0_rsp_valid = tv[i].rsv;
            bus.c0_rsp_tag   = tv[i].rst;
            bus.c1_req_valid = tv[i].wq;
            bus.c1_rsp_valid = tv[i].wr;
            step();
            chk($sformatf("v%0d err_valid", i), 32'(err_valid), 32'(tv[i].ev));
            chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(tv[i].ec));
            chk($sformatf("v%0d rd_out", i), 32'(rd_outstanding), 32'(tv[i].rdo));
            chk($sformatf("v%0d wr_out", i), wr_outstanding, tv[i].wro);
        end
        idle();
        step();
        chk("tbl rd_req_cnt", rd_req_cnt, 5);
        chk("tbl rd_rsp_cnt", rd_rsp_cnt, 6);
        chk("tbl wr_req_cnt", wr_req_cnt, 4);
        chk("tbl wr_rsp_cnt", wr_rsp_cnt, 6);
        chk("tbl max_lat", 32'(max_rd_latency), 2);
        chk("tbl sticky", 32'(err_sticky), 1);
        chk("tbl first_code", 32'(err_first_code), 5);
        chk("tbl first_tag", 32'(err_first_tag), 0);

        // Clear drops same-cycle counting but not outstanding tracking
        stats_clear      = 1'b1;
        bus.c1_req_valid = 1'b1;
        step();
        idle();
        chk("clr wr_req_cnt", wr_req_cnt, 0);
        chk("clr rd_rsp_cnt", rd_rsp_cnt, 0);
        chk("clr wr_out", wr_outstanding, 1);
        chk("clr sticky", 32'(err_sticky), 0);
        chk("clr max_lat", 32'(max_rd_latency), 0);
        bus.c1_rsp_valid = 1'b1;
        step();
        idle();
        chk("clr2 wr_out", wr_outstanding, 0);
        chk("clr2 wr_rsp_cnt", wr_rsp_cnt, 1);

        // 4-CL read, beats sampled 10..13 cycles after the request
        errs_seen = 0;
        rd_req(8'h05, 2'b11);
        step();
        idle();
        chk("t1 rd_out open", 32'(rd_outstanding), 1);
        for (int k = 1; k < 10; k++) begin
            step();
            errs_seen += int'(err_valid);
        end
        for (int k = 0; k < 4; k++) begin
            rd_rsp(8'h05);
            step();
            errs_seen += int'(err_valid);
        end
        idle();
        chk("t1 rd_out done", 32'(rd_outstanding), 0);
        chk("t1 rd_rsp_cnt", rd_rsp_cnt, 4);
        chk("t1 max_lat", 32'(max_rd_latency), 13);
        chk("t1 no errors", errs_seen, 0);

        // Duplicate tag
        rd_req(8'h07, 2'b00);
        step();
        rd_req(8'h07, 2'b00);
        step();
        idle();
        chk("t2 err_valid", 32'(err_valid), 1);
        chk("t2 err_code", 32'(err_code), 1);
        chk("t2 first_tag", 32'(err_first_tag), 32'h07);
        chk("t2 rd_out", 32'(rd_outstanding), 1);
        rd_rsp(8'h07);
        step();
        idle();
        chk("t2 done err", 32'(err_valid), 0);
        chk("t2 done rd_out", 32'(rd_outstanding), 0);

        // Same-cycle free and re-allocate
        rd_req(8'h20, 2'b00);
        step();
        rd_req(8'h20, 2'b00);
        rd_rsp(8'h20);
        step();
        idle();
        chk("t4 err_valid", 32'(err_valid), 0);
        chk("t4 rd_out", 32'(rd_outstanding), 1);
        rd_rsp(8'h20);
        step();
        idle();
        chk("t4 done rd_out", 32'(rd_outstanding), 0);

        // Timeout then late response
        stats_clear = 1'b1;
        step();
        idle();
        rd_req(8'h10, 2'b00);
        step();
        idle();
        n = 0;
        for (int k = 1; k <= TMO + 300; k++) begin
            step();
            if (err_valid) begin
                n = k;
                break;
            end
        end
        chk("t3 timeout seen", 32'(n != 0), 1);
        chk("t3 window", 32'(n >= TMO && n < TMO + 256), 1);
        chk("t3 err_code", 32'(err_code), 3);
        chk("t3 first_tag", 32'(err_first_tag), 32'h10);
        chk("t3 rd_out", 32'(rd_outstanding), 0);
        rd_rsp(8'h10);
        step();
        idle();
        chk("t3 late err_valid", 32'(err_valid), 1);
        chk("t3 late err_code", 32'(err_code), 2);

        // Reset with reads outstanding
        rd_req(8'h01, 2'b00);
        step();
        rd_req(8'h02, 2'b01);
        step();
        rd_req(8'h03, 2'b11);
        step();
        idle();
        chk("t6 rd_out", 32'(rd_outstanding), 3);
        SoftReset        = 1'b1;
        bus.c1_req_valid = 1'b1;
        step();
        chk_zero("t6 reset");
        idle();
        SoftReset = 1'b0;
        rd_rsp(8'h02);
        step();
        idle();
        chk("t6 stale err_valid", 32'(err_valid), 1);
        chk("t6 stale err_code", 32'(err_code), 2);
        chk("t6 stale first_tag", 32'(err_first_tag), 32'h02);
        chk("t6 stale rd_out", 32'(rd_outstanding), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccip_txn_monitor.md
Name: ccip_txn_monitor

Overview:
Synthesizable CCI-P transaction monitor that sits beside the AFU on the ccip_rx/ccip_tx boundary. It is the hardware successor to the simulation-only text logger.
- Tracks every outstanding read by mdata tag, including multi-cacheline reads.
- Measures read latency, detects protocol errors and timeouts, and keeps per-channel transaction counters.
- Results are readable by CSR logic at runtime, on silicon as well as in ASE.

Parameters:
TAG_WIDTH, 8, mdata LSBs used as read tag; tracking table depth = 2^TAG_WIDTH
LAT_WIDTH, 16, width of timestamp and latency values
TIMEOUT_CYCLES, 4096, read age at which a timeout is declared; must satisfy TIMEOUT_CYCLES + 2^TAG_WIDTH < 2^LAT_WIDTH
CNT_WIDTH, 32, width of transaction counters

Ports:
clk  in  1  interface clock; one clock only
SoftReset  in  1  synchronous, active-high reset
c0_req_valid  in  1  AFU read request (RdLine_I/RdLine_S only) this cycle
c0_req_tag  in  TAG_WIDTH  mdata[TAG_WIDTH-1:0] of read request
c0_req_len  in  2  cl_len of the request: 00=1 CL, 01=2 CL, 11=4 CL, 10=illegal
c0_rsp_valid  in  1  RdLine response this cycle (UMsg/MMIO excluded upstream)
c0_rsp_tag  in  TAG_WIDTH  mdata[TAG_WIDTH-1:0] of read response
c1_req_valid  in  1  WrLine_I/WrLine_M request this cycle (fences and interrupts excluded)
c1_rsp_valid  in  1  WrLine response this cycle
stats_clear  in  1  one-cycle pulse; clears counters, max latency and error capture
rd_req_cnt  out  CNT_WIDTH  read requests accepted
rd_rsp_cnt  out  CNT_WIDTH  read response beats received
wr_req_cnt  out  CNT_WIDTH  write requests
wr_rsp_cnt  out  CNT_WIDTH  write responses
rd_outstanding  out  TAG_WIDTH+1  number of valid table entries
wr_outstanding  out  CNT_WIDTH  writes issued but not yet responded
max_rd_latency  out  LAT_WIDTH  largest completed-read latency in cycles
err_valid  out  1  one-cycle pulse per detected error
err_code  out  3  code of the pulsed error
err_sticky  out  1  set on first error; held until clear
err_first_code  out  3  code of the first error since clear
err_first_tag  out  TAG_WIDTH  tag of the first error since clear

Behaviour:
Reset:
- All outputs 0 after the clock edge where SoftReset=1.
- Table entries invalidated, timestamp counter 0, scan pointer 0.
- Inputs are ignored during reset.

Timestamp:
- Free-running LAT_WIDTH counter; wraps.
- Ages and latencies are computed as modular (now - ts).

Table entry:
- Each entry holds {valid, remaining[2:0], ts}.

Read request:
- If the entry is free: valid=1, remaining=1/2/4 per c0_req_len, ts=now; rd_req_cnt+1.
- If the entry is valid: error 1 (duplicate tag); the entry is left unchanged and still counted.
- c0_req_len=10: error 4; no allocation; still counted.

Read response:
- rd_rsp_cnt+1 on every beat.
- If the entry is valid: remaining-1. When remaining reaches 0, the entry frees and max_rd_latency = max(old, now - ts).
- If the entry is invalid: error 2 (orphan).

Same-cycle response and request on the same tag:
- The response is applied first.
- If the response frees the entry, the request allocates with no error.
- Otherwise the request raises error 1.

Timeout scan:
- One entry per cycle, pointer wraps at 2^TAG_WIDTH.
- If the scanned entry is valid and age >= TIMEOUT_CYCLES: error 3 with that entry's tag, and the entry frees.
- A response to the same entry in the same cycle takes priority and cancels the timeout.
- A later response to a timed-out tag raises error 2.

Writes:
- wr_req_cnt and wr_rsp_cnt increment on their valids.
- wr_outstanding = +req - rsp; simultaneous req and rsp leave it unchanged.
- A response while wr_outstanding=0 (and no same-cycle request) raises error 5 and leaves wr_outstanding at 0.

Multiple errors in one cycle:
- err_valid pulses once, reporting the lowest code.
- err_first_* latches only while err_sticky=0.
- Outputs are registered: they reflect events one cycle after the input edge.

Counters:
- Wrap at 2^CNT_WIDTH.
- stats_clear zeroes counters, max_rd_latency and the err_* fields next cycle; events in that same cycle are dropped.
- stats_clear does not touch the table, rd_outstanding or wr_outstanding.

Test Plan:
1. Read tag 0x05 len 11, four responses at cycles +10..+13 -> rd_outstanding 1→0; rd_rsp_cnt=4; max_rd_latency=13; no error.
2. Read tag 0x07, second read tag 0x07 before its response -> err_valid with code 1, err_first_tag=0x07; the entry still completes after one response.
3. Read tag 0x10, no response -> code 3 within TIMEOUT_CYCLES..TIMEOUT_CYCLES+256 cycles; a late response then gives code 2.
4. Tag 0x20 len 00: response and new request on 0x20 in the same cycle -> no error; rd_outstanding stays 1.
5. Write response with no writes outstanding -> code 5; wr_outstanding stays 0. Then 3 requests and 3 responses -> wr_outstanding returns to 0.
6. SoftReset asserted with 3 reads outstanding -> all outputs 0 next cycle; old tags' later responses give code 2.
